// File: rtl/err_inj_pkg.sv
// err_inj_pkg: shared types and default widths for the error-injection sequencer and control routers
// Exports the sequencer state enum and the default DFF-ID and counter widths.
package err_inj_pkg;
   localparam int ID_W_DEF  = 16;
   localparam int CNT_W_DEF = 16;
   typedef enum logic [1:0] {IDLE, GAP, INJECT, DONE} state_t;
endpackage

// File: rtl/error_injection_sequencer_if.sv
// error_injection_sequencer_if: host config handshake plus error-injection control bus
// master: host side (drives cfg_* and abort, observes status and the injection bus)
// slave : sequencer side (accepts cfg_*, drives err_en/err_ctrl and status)
interface error_injection_sequencer_if
   import err_inj_pkg::*;
#(
   parameter int ID_W  = ID_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [ID_W-1:0]  cfg_first_id;
   logic [ID_W-1:0]  cfg_last_id;
   logic [CNT_W-1:0] cfg_gap;
   logic [CNT_W-1:0] cfg_pulse;
   logic             abort;
   logic             err_en;
   logic [ID_W-1:0]  err_ctrl;
   logic             busy;
   logic             done;
   logic             aborted;
   logic             range_err;
   logic [ID_W:0]    inj_count;
   modport master (
      output cfg_valid, cfg_first_id, cfg_last_id, cfg_gap, cfg_pulse, abort,
      input  cfg_ready, err_en, err_ctrl, busy, done, aborted, range_err, inj_count
   );
   modport slave (
      input  cfg_valid, cfg_first_id, cfg_last_id, cfg_gap, cfg_pulse, abort,
      output cfg_ready, err_en, err_ctrl, busy, done, aborted, range_err, inj_count
   );
endinterface

// File: rtl/err_inj_downcounter.sv
// err_inj_downcounter: loadable down-counter with zero flag, shared by gap and pulse timing
// Ports: clk, rst (async high), load/load_val (load wins), dec (stops at 0), count, zero.
module err_inj_downcounter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             zero
);
   assign zero = count == '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (load) count <= load_val;
      else if (dec && !zero) count <= count - 1'b1;
endmodule

// File: rtl/error_injection_sequencer.sv
// error_injection_sequencer: walks a DFF-ID range issuing one timed err_en pulse per ID
// Ports: clk, rst (async high), bus (slave modport: cfg handshake, abort, err_en/err_ctrl, status).
// The shared counter is loaded with (cycles - 1) so its zero flag marks the last cycle of a phase.
module error_injection_sequencer
   import err_inj_pkg::*;
#(
   parameter int ID_W  = ID_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic                        clk,
   input logic                        rst,
   error_injection_sequencer_if.slave bus
);
   state_t           state;
   logic [ID_W-1:0]  last_id;
   logic [CNT_W-1:0] gap_r, pulse_r, pulse_in, cnt_val, count;
   logic             accept_ok, gap_end, pulse_end, is_last, cnt_load, cnt_dec, zero;
   assign bus.cfg_ready = state == IDLE;
   assign bus.busy      = state != IDLE;
   always_comb begin
      pulse_in  = bus.cfg_pulse == '0 ? CNT_W'(1) : bus.cfg_pulse;
      accept_ok = state == IDLE && bus.cfg_valid && bus.cfg_first_id <= bus.cfg_last_id;
      gap_end   = state == GAP && zero;
      pulse_end = state == INJECT && zero;
      is_last   = bus.err_ctrl == last_id;
      cnt_load  = accept_ok || gap_end || (pulse_end && !is_last);
      cnt_dec   = state == GAP || state == INJECT;
      cnt_val   = accept_ok ? (bus.cfg_gap != '0 ? bus.cfg_gap - 1'b1 : pulse_in - 1'b1)
                : (state == GAP || gap_r == '0) ? pulse_r - 1'b1 : gap_r - 1'b1;
   end
   err_inj_downcounter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .load(cnt_load), .dec(cnt_dec),
      .load_val(cnt_val), .count(count), .zero(zero)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_id       <= '0;
         gap_r         <= '0;
         pulse_r       <= '0;
         bus.err_en    <= 1'b0;
         bus.err_ctrl  <= '0;
         bus.done      <= 1'b0;
         bus.aborted   <= 1'b0;
         bus.range_err <= 1'b0;
         bus.inj_count <= '0;
      end else begin
         bus.done      <= 1'b0;
         bus.aborted   <= 1'b0;
         bus.range_err <= 1'b0;
         case (state)
            IDLE:
               if (bus.cfg_valid) begin
                  if (!accept_ok) bus.range_err <= 1'b1;
                  else begin
                     last_id       <= bus.cfg_last_id;
                     gap_r         <= bus.cfg_gap;
                     pulse_r       <= pulse_in;
                     bus.err_ctrl  <= bus.cfg_first_id;
                     bus.inj_count <= '0;
                     bus.err_en    <= bus.cfg_gap == '0;
                     state         <= bus.cfg_gap == '0 ? INJECT : GAP;
                  end
               end
            GAP:
               if (bus.abort) begin
                  state       <= DONE;
                  bus.done    <= 1'b1;
                  bus.aborted <= 1'b1;
               end else if (zero) begin
                  state      <= INJECT;
                  bus.err_en <= 1'b1;
               end
            INJECT: begin
               // a pulse finishing in the same cycle as abort still counts
               if (zero) bus.inj_count <= bus.inj_count + 1'b1;
               if (bus.abort || (zero && is_last)) begin
                  state       <= DONE;
                  bus.done    <= 1'b1;
                  bus.aborted <= bus.abort;
                  bus.err_en  <= 1'b0;
               end else if (zero) begin
                  bus.err_ctrl <= bus.err_ctrl + 1'b1;
                  bus.err_en   <= gap_r == '0;
                  state        <= gap_r == '0 ? INJECT : GAP;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
